// File: rtl/fir_tx_pkg.sv
// -----------------------------------------------------------------------------
// fir_tx_pkg
//   Shared types and constants for the checkbits transmitter.
//   - tx_state_t : transmitter FSM states
//   - DEF_*      : default marker words used as parameter defaults
// -----------------------------------------------------------------------------
package fir_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FETCH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_END   = 3'd4,
        ST_SUM   = 3'd5
    } tx_state_t;

    localparam logic [15:0] DEF_START_MARK = 16'hAB40;
    localparam logic [15:0] DEF_END_MARK   = 16'hAB51;
    localparam logic [15:0] DEF_IDLE_WORD  = 16'h0000;

endpackage

// File: rtl/fir_tx_fifo.sv
// -----------------------------------------------------------------------------
// fir_tx_fifo
//   Small synchronous FIFO buffering FIR samples ahead of the word sequencer.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     flush      : empties the FIFO; a push in the same cycle survives as the
//                  only entry
//     push, din  : write request and data (ignored when full unless popping)
//     pop, dout  : read request and head-of-FIFO data (ignored when empty)
//     full, empty: occupancy flags
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fir_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO may still accept a write when it is being read or flushed.
    assign do_push = push & (~full | do_pop | flush);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[flush ? '0 : wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_checkbits_tx.sv
// -----------------------------------------------------------------------------
// fir_checkbits_tx
//   Publishes FIR output samples on the checkbits pads as one frame:
//   START_MARK, TEST_LENGTH samples, END_MARK. Every word is held for at least
//   HOLD_CYCLES and each new word (even an identical value) toggles word_tgl.
//   Ports:
//     wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//     arm                : 1-cycle pulse starting a frame (ignored while busy)
//     s_tvalid/s_tready/s_tdata/s_tlast : AXI-Stream sample input
//     checkbits          : word driven to the pads
//     checkbits_oeb      : pad output enables, active-low (always driven)
//     word_tgl           : toggles on every new word
//     busy               : frame in progress (START through last sample)
//     len_err            : sticky, s_tlast position disagrees with TEST_LENGTH
//   Handshake: a sample transfers on a rising edge where s_tvalid and s_tready
//   are both high; s_tready is high whenever the FIFO has room and the
//   transmitter has been armed at least once. Samples past TEST_LENGTH are
//   accepted and dropped so the FIR never stalls.
//   Optional feature: define FIR_TX_CHECKSUM_EN to append the 16-bit
//   wrap-around sum of the transmitted samples after END_MARK (state ST_SUM).
//   The FSM state is visible as the internal signal 'state'.
// -----------------------------------------------------------------------------
module fir_checkbits_tx
    import fir_tx_pkg::*;
#(
    parameter int          TEST_LENGTH = 64,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 8,
    parameter logic [15:0] START_MARK  = DEF_START_MARK,
    parameter logic [15:0] END_MARK    = DEF_END_MARK,
    parameter logic [15:0] IDLE_WORD   = DEF_IDLE_WORD
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        arm,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [31:0] s_tdata,
    input  logic        s_tlast,
    output logic [15:0] checkbits,
    output logic [15:0] checkbits_oeb,
    output logic        word_tgl,
    output logic        busy,
    output logic        len_err
);

    localparam int CW = $clog2(TEST_LENGTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LEN      = CW'(TEST_LENGTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(TEST_LENGTH - 1);
    localparam logic [HW-1:0] HOLD_N   = HW'(HOLD_CYCLES);
    // Leaving for FETCH one cycle early lets the next word land exactly
    // HOLD_CYCLES after the current one when the FIFO already has data.
    localparam logic [HW-1:0] HOLD_M1  = HW'(HOLD_CYCLES - 1);

    tx_state_t     state, state_d;
    logic [15:0]   checkbits_d;
    logic          tgl_d;
    logic          busy_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [CW-1:0] cnt_out, cnt_out_d;
    logic [CW-1:0] cnt_in, cnt_base;
    logic          arm_go;
    logic          accept;
    logic          push;
    logic          pop;
    logic          tlast_bad;
    logic [15:0]   fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          unused_hi;

`ifdef FIR_TX_CHECKSUM_EN
    logic [15:0]   sum, sum_d;
`endif

    assign unused_hi     = ^s_tdata[31:16];
    assign checkbits_oeb = 16'h0000;
    assign arm_go        = arm & ~busy;
    assign s_tready      = ~fifo_full & (state != ST_IDLE);
    assign accept        = s_tvalid & s_tready;

    // A sample accepted in the arming cycle belongs to the new frame.
    assign cnt_base  = arm_go ? '0 : cnt_in;
    assign push      = accept & (cnt_base < LEN);
    assign tlast_bad = accept & (s_tlast != (cnt_base == LAST_IDX));

    fir_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (arm_go),
        .push  (push),
        .din   (s_tdata[15:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Input-side sample counter and length check.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_in  <= '0;
            len_err <= 1'b0;
        end else begin
            if (push) begin
                cnt_in <= cnt_base + 1'b1;
            end else begin
                cnt_in <= cnt_base;
            end
            len_err <= (arm_go ? 1'b0 : len_err) | tlast_bad;
        end
    end

    // FSM state and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            checkbits <= IDLE_WORD;
            word_tgl  <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            cnt_out   <= '0;
`ifdef FIR_TX_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_d;
            checkbits <= checkbits_d;
            word_tgl  <= tgl_d;
            busy      <= busy_d;
            hold_cnt  <= hold_d;
            cnt_out   <= cnt_out_d;
`ifdef FIR_TX_CHECKSUM_EN
            sum       <= sum_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        checkbits_d = checkbits;
        tgl_d       = word_tgl;
        busy_d      = busy;
        hold_d      = (hold_cnt < HOLD_N) ? hold_cnt + 1'b1 : hold_cnt;
        cnt_out_d   = cnt_out;
        pop         = 1'b0;
`ifdef FIR_TX_CHECKSUM_EN
        sum_d       = sum;
`endif

        case (state)
            ST_IDLE, ST_END, ST_SUM: begin
                if (arm_go) begin
                    state_d     = ST_START;
                    checkbits_d = START_MARK;
                    tgl_d       = ~word_tgl;
                    busy_d      = 1'b1;
                    hold_d      = HW'(1);
                    cnt_out_d   = '0;
`ifdef FIR_TX_CHECKSUM_EN
                    sum_d       = '0;
                end else if (state == ST_END && hold_cnt >= HOLD_N) begin
                    state_d     = ST_SUM;
                    checkbits_d = sum;
                    tgl_d       = ~word_tgl;
                    hold_d      = HW'(1);
`endif
                end
            end

            ST_START: begin
                if (hold_cnt >= HOLD_M1) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    state_d     = ST_HOLD;
                    checkbits_d = fifo_dout;
                    tgl_d       = ~word_tgl;
                    hold_d      = HW'(1);
                    cnt_out_d   = cnt_out + 1'b1;
`ifdef FIR_TX_CHECKSUM_EN
                    sum_d       = sum + fifo_dout;
`endif
                end
            end

            ST_HOLD: begin
                if (cnt_out == LEN) begin
                    // END_MARK replaces the last sample directly, so wait the
                    // full hold here.
                    if (hold_cnt >= HOLD_N) begin
                        state_d     = ST_END;
                        checkbits_d = END_MARK;
                        tgl_d       = ~word_tgl;
                        busy_d      = 1'b0;
                        hold_d      = HW'(1);
                    end
                end else if (hold_cnt >= HOLD_M1) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_checkbits_tx.sv
// -----------------------------------------------------------------------------
// tb_fir_checkbits_tx
//   Self-checking bench for fir_checkbits_tx. The reference model is the
//   ordered list of words a frame must show (START, samples, END[, sum]) kept
//   in exp_q, plus per-word minimum hold, toggle count and length-error rules.
// -----------------------------------------------------------------------------
module tb_fir_checkbits_tx;

    localparam int          TEST_LENGTH = 64;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          HOLD_CYCLES = 8;
    localparam logic [15:0] START_W     = 16'hAB40;
    localparam logic [15:0] END_W       = 16'hAB51;
    localparam logic [15:0] IDLE_W      = 16'h0000;
`ifdef FIR_TX_CHECKSUM_EN
    localparam int          EXP_TGL     = TEST_LENGTH + 3;
`else
    localparam int          EXP_TGL     = TEST_LENGTH + 2;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        arm;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [15:0] checkbits;
    logic [15:0] checkbits_oeb;
    logic        word_tgl;
    logic        busy;
    logic        len_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    fir_checkbits_tx #(
        .TEST_LENGTH (TEST_LENGTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES),
        .START_MARK  (START_W),
        .END_MARK    (END_W),
        .IDLE_WORD   (IDLE_W)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .arm           (arm),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .checkbits     (checkbits),
        .checkbits_oeb (checkbits_oeb),
        .word_tgl      (word_tgl),
        .busy          (busy),
        .len_err       (len_err)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          tgl_cnt  = 0;
    int          dur      = 0;
    logic        prev_tgl = 1'b0;
    logic        mon_first = 1'b1;
    logic        saw_stall = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Word monitor: every word_tgl change must present the next expected word,
    // and the word it replaces must have been shown at least HOLD_CYCLES.
    always @(negedge clk) begin
        logic [15:0] w;
        if (rst) begin
            prev_tgl = word_tgl;
            dur      = 0;
        end else if (word_tgl !== prev_tgl) begin
            prev_tgl = word_tgl;
            tgl_cnt++;
            if (!mon_first) begin
                check_eq("hold_min", 32'(dur >= HOLD_CYCLES), 32'd1);
            end
            mon_first = 1'b0;
            dur       = 1;
            check_eq("exp_word_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check_eq("word", {16'h0, checkbits}, {16'h0, w});
            end
        end else begin
            dur++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_sample(input logic [31:0] d, input logic last);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        n = 0;
        while (!s_tready && n < 2000) begin
            saw_stall = 1'b1;
            @(negedge clk);
            n++;
        end
        check_eq("tready_wait", {31'h0, s_tready}, 32'd1);
        @(negedge clk);
    endtask

    // mode: 0 random data with gaps, 1 back-to-back, 2 leading 5,5,5, 3 data 1..N
    // tl_pos: index carrying s_tlast (-1 = last sample); rst_after: reset after N samples
    task automatic run_frame(input int mode, input int tl_pos, input int rst_after);
        logic [31:0] d;
        logic        last;
        logic        exp_err;
        logic [15:0] exp_sum;
        int          n;
        exp_err   = 1'b0;
        exp_sum   = '0;
        saw_stall = 1'b0;
        mon_first = 1'b1;
        tgl_cnt   = 0;
        exp_q.push_back(START_W);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check_eq("busy_after_arm", {31'h0, busy}, 32'd1);
        check_eq("len_err_clr", {31'h0, len_err}, 32'd0);
        for (int i = 0; i < TEST_LENGTH; i++) begin
            if (mode == 0 && i == 30) begin
                arm = 1'b1;
                @(negedge clk);
                arm = 1'b0;
            end
            d = $urandom;
            if (mode == 3) d = 32'(i + 1);
            if (mode == 2 && i < 3) d = {d[31:16], 16'd5};
            last = (tl_pos < 0) ? (i == TEST_LENGTH - 1) : (i == tl_pos);
            if (last != (i == TEST_LENGTH - 1)) exp_err = 1'b1;
            exp_q.push_back(d[15:0]);
            exp_sum = exp_sum + d[15:0];
            send_sample(d, last);
            check_eq("len_err_run", {31'h0, len_err}, {31'h0, exp_err});
            if (rst_after == i + 1) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                rst = 1'b1;
                #1;
                check_eq("rst_mid_checkbits", {16'h0, checkbits}, {16'h0, IDLE_W});
                check_eq("rst_mid_busy", {31'h0, busy}, 32'd0);
                check_eq("rst_mid_tgl", {31'h0, word_tgl}, 32'd0);
                check_eq("rst_mid_tready", {31'h0, s_tready}, 32'd0);
                check_eq("rst_mid_len_err", {31'h0, len_err}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (mode != 1) begin
                s_tvalid = 1'b0;
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        exp_q.push_back(END_W);
`ifdef FIR_TX_CHECKSUM_EN
        exp_q.push_back(exp_sum);
`endif
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_end_busy", {31'h0, busy}, 32'd0);
        repeat (HOLD_CYCLES + 4) @(negedge clk);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_eq("tgl_count", 32'(tgl_cnt), 32'(EXP_TGL));
        check_eq("len_err_final", {31'h0, len_err}, {31'h0, exp_err});
        if (mode == 1) check_eq("tready_drop", {31'h0, saw_stall}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst      = 1'b1;
        arm      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_checkbits", {16'h0, checkbits}, {16'h0, IDLE_W});
        check_eq("rst_oeb", {16'h0, checkbits_oeb}, 32'h0);
        check_eq("rst_tgl", {31'h0, word_tgl}, 32'd0);
        check_eq("rst_busy", {31'h0, busy}, 32'd0);
        check_eq("rst_len_err", {31'h0, len_err}, 32'd0);
        check_eq("rst_tready", {31'h0, s_tready}, 32'd0);
        rst = 1'b0;
        s_tvalid = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_tready", {31'h0, s_tready}, 32'd0);
        check_eq("idle_checkbits", {16'h0, checkbits}, {16'h0, IDLE_W});
        s_tvalid = 1'b0;

        run_frame(3, -1, 0);   // data 1..64
        run_frame(1, -1, 0);   // back-to-back, FIFO fills
        run_frame(2, -1, 0);   // repeated identical samples
        run_frame(0, 9, 0);    // early tlast on sample 10
        run_frame(0, -1, 20);  // reset mid-frame
        run_frame(0, -1, 0);   // clean frame after reset
        check_eq("end_oeb", {16'h0, checkbits_oeb}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
